video_fetch_shifter: RTL
========================

Name: video_fetch_shifter

Overview:
- Parametrised successor to the fixed ColourGenie video path.
- Walks a character line autonomously instead of sampling the CRTC every character. For each character it fetches screen code, colour attribute and glyph byte through a single request/acknowledge memory port, which may be backed by BRAM or SDRAM with variable latency.
- Holds a one-character prefetch buffer and shifts out pixels in three modes: text, hires 2bpp and hires 1bpp.
- Sits between the CRTC timing and the palette/DAC stage.

Parameters:
- AW, 16, memory port address width.
- COLS, 40, characters per active line (1..255).
- PPC, 8, pixel ticks per character slot; must be a multiple of 4, max 16.
- SCREEN_BASE, 16'h4000, base address of screen RAM.
- COLOR_BASE, 16'hF000, base address of colour RAM (1 KB window, low nibble used).
- FONT_BASE, 16'h0000, base of ROM font (code*8 + row).
- UDG_BASE, 16'hF400, base of programmable character RAM (code[6:0]*8 + row).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- pce, input, 1, pixel tick enable.
- line_start, input, 1, one-cycle pulse; latches start address and glyph row, starts prefetch.
- de, input, 1, display enable; pixels advance only on pce && de.
- vma, input, 14, character start address for the line.
- vra, input, 3, glyph row.
- mode, input, 2, display mode: 0 text, 1 hires 2bpp, 2 hires 1bpp, 3 reserved (treated as 0).
- b, input, 1, UDG select for codes 0xC0-0xFF (low = use UDG).
- c, input, 1, UDG select for codes 0x80-0xBF (low = use UDG).
- mem_req, output, 1, memory read request.
- mem_addr, output, AW, read address.
- mem_ack, input, 1, one-cycle acknowledge; mem_q valid in the same cycle.
- mem_q, input, 8, read data.
- ven, output, 1, pixel foreground flag.
- color, output, 4, pixel colour index.
- underrun, output, 1, sticky error flag; cleared by reset or line_start.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, ven=0, color=0, underrun=0. FSM goes to IDLE; buffer and shifter are empty.
- line_start handling:
  - Latches vma into a 14-bit address counter and vra into the row register.
  - Sets fetched=0, clears the buffer, shifter and underrun.
  - Enters FETCH_CODE.
  - A line_start that arrives mid-fetch aborts the outstanding request, but only after its ack. mem_req stays high until that ack and the returned data is discarded.
- FSM states: IDLE, FETCH_CODE, FETCH_ATTR, FETCH_GLYPH, WAIT_BUF.
  - FETCH_CODE: addr = SCREEN_BASE + vma_cnt. On ack, store code.
    - Mode 0 goes to FETCH_ATTR.
    - Mode 1 goes to WAIT_BUF.
    - Mode 2 goes to FETCH_ATTR; the glyph is not fetched.
  - FETCH_ATTR: addr = COLOR_BASE + vma_cnt[9:0]. On ack, store mem_q[3:0]. Mode 0 goes to FETCH_GLYPH, mode 2 goes to WAIT_BUF.
  - FETCH_GLYPH: UDG is selected when code[7] && ((!c && !code[6]) || (!b && code[6])).
    - UDG: addr = UDG_BASE + {code[6:0], vra}.
    - Otherwise: addr = FONT_BASE + {code, vra}.
    - On ack, store the glyph and go to WAIT_BUF.
  - WAIT_BUF: when the buffer is empty, load it; increment vma_cnt (wraps modulo 2^14) and fetched.
    - fetched == COLS goes to IDLE.
    - Otherwise go to FETCH_CODE.
- mem_req is asserted in the cycle after entering a FETCH state and held with mem_addr stable until ack. Deassert in the ack cycle. Never issue back-to-back requests without one idle cycle between them.
- Shifter, advanced on pce && de:
  - Slot counter 0..PPC-1. At slot 0, move buffer to shifter and mark the buffer empty.
  - Mode 0: pattern = glyph bits MSB first, one bit per tick for the first 8 ticks, then 0. ven = bit; color = attr.
  - Mode 2: pattern = code bits, same timing as mode 0; color = attr.
  - Mode 1: code is split into 4 pixels of PPC/4 ticks each. Pair order is {7,6}, {5,4}, {3,2}, {1,0}.
    - Pair values 0/1/2/3 map to colour 0/8/2/5.
    - ven = (pair != 0).
  - Output registers update on the same pce, giving 1-clock latency from pce to valid output.
- Underrun: at slot 0 with the buffer empty, the whole slot outputs ven=0 and color=0, and underrun sets to 1. The FSM keeps fetching; the late character is shown in the next slot.
- With de low, the slot counter holds and outputs hold ven=0, color=0. When de rises again, output resumes at the held slot.
- After COLS characters have been shifted, output is ven=0 until the next line_start.

Test Plan:
- Mode 0 with zero-latency ack: code 0x41 at 0x4000, attr 0x5, font(0x41,row2)=0x3C. Expect ven pattern 00111100 with color=5, and addresses 0x4000, 0xF000, 0x020A in order.
- UDG select: code 0x85 with c=0 requests addr 0xF42A at row 2; with c=1 it requests 0x042A.
- Mode 1, PPC=8, code 0x1B: color sequence 0,0,8,8,2,2,5,5 and ven 0,0,1,1,1,1,1,1.
- Slow ack (latency 6 clocks, pce every cycle): underrun=1, the first slot is blank, and the character appears one slot late.
- vma=0x3FFF, COLS=2: second screen fetch addr = SCREEN_BASE+0x0000; colour addr is 0xF3FF then 0xF000.
- line_start during pending request with ack at +3: mem_req stays high until ack, then a new request to the new vma address follows. The stale data never appears on ven.

Source files
------------

// File: rtl/video_fetch_shifter.sv
// Character-line fetch engine and pixel shifter between CRTC timing and palette.
// One request/ack memory port, one-character prefetch buffer, three pixel modes.
module video_fetch_shifter #(
  parameter int AW = 16,
  parameter int COLS = 40,
  parameter int PPC = 8,
  parameter logic [AW-1:0] SCREEN_BASE = 16'h4000,
  parameter logic [AW-1:0] COLOR_BASE = 16'hF000,
  parameter logic [AW-1:0] FONT_BASE = 16'h0000,
  parameter logic [AW-1:0] UDG_BASE = 16'hF400
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pce,
  input  logic          line_start,
  input  logic          de,
  input  logic [13:0]   vma,
  input  logic [2:0]    vra,
  input  logic [1:0]    mode,
  input  logic          b,
  input  logic          c,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_q,
  output logic          ven,
  output logic [3:0]    color,
  output logic          underrun
);

  localparam int QW = PPC / 4;

  typedef enum logic [2:0] {
    IDLE, FETCH_CODE, FETCH_ATTR, FETCH_GLYPH, WAIT_BUF
  } state_t;

  state_t state;
  logic [13:0] vmaCnt;
  logic [2:0] rowReg;
  logic [1:0] lineMode;
  logic [7:0] fetched;
  logic drop;
  logic [7:0] code, glyph;
  logic [3:0] attr;
  logic bufFull, shValid;
  logic [7:0] bufCode, bufGlyph, shCode, shGlyph;
  logic [3:0] bufAttr, shAttr;
  logic [3:0] slot;
  logic [7:0] shown;
  logic useUdg, loadBuf, got, adv;
  logic [AW-1:0] reqAddr;
  logic srcOn;
  logic [7:0] srcCode, srcGlyph;
  logic [3:0] srcAttr;
  logic [1:0] pair;
  logic pixVen;
  logic [3:0] pixColor;

  assign useUdg = code[7] && ((!c && !code[6]) || (!b && code[6]));
  assign loadBuf = (state == WAIT_BUF) && !bufFull && !line_start;
  assign got = mem_req && mem_ack;
  assign adv = pce && de;

  // Address for the fetch belonging to the current state
  always_comb begin
    reqAddr = '0;
    unique case (state)
      FETCH_CODE: reqAddr = SCREEN_BASE + AW'(vmaCnt);
      FETCH_ATTR: reqAddr = COLOR_BASE + AW'(vmaCnt[9:0]);
      FETCH_GLYPH:
        reqAddr = useUdg ? UDG_BASE + AW'({code[6:0], rowReg})
                         : FONT_BASE + AW'({code, rowReg});
      default: ;
    endcase
  end

  // Fetch sequencer; a restart mid-request waits for and drops the stale ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_addr <= '0;
      drop <= 1'b0;
      vmaCnt <= '0;
      rowReg <= '0;
      lineMode <= '0;
      fetched <= '0;
      code <= '0;
      attr <= '0;
      glyph <= '0;
    end else if (line_start) begin
      state <= FETCH_CODE;
      vmaCnt <= vma;
      rowReg <= vra;
      lineMode <= (mode == 2'd3) ? 2'd0 : mode;
      fetched <= '0;
      if (mem_req && !mem_ack) begin
        drop <= 1'b1;
      end else begin
        drop <= 1'b0;
        mem_req <= 1'b0;
      end
    end else if (drop) begin
      if (mem_ack) begin
        drop <= 1'b0;
        mem_req <= 1'b0;
      end
    end else begin
      unique case (state)
        FETCH_CODE, FETCH_ATTR, FETCH_GLYPH: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_addr <= reqAddr;
          end else if (got) begin
            mem_req <= 1'b0;
            if (state == FETCH_CODE) begin
              code <= mem_q;
              state <= (lineMode == 2'd1) ? WAIT_BUF : FETCH_ATTR;
            end else if (state == FETCH_ATTR) begin
              attr <= mem_q[3:0];
              state <= (lineMode == 2'd2) ? WAIT_BUF : FETCH_GLYPH;
            end else begin
              glyph <= mem_q;
              state <= WAIT_BUF;
            end
          end
        end
        WAIT_BUF: begin
          if (!bufFull) begin
            vmaCnt <= vmaCnt + 14'd1;
            fetched <= fetched + 8'd1;
            state <= (fetched + 8'd1 == 8'(COLS)) ? IDLE : FETCH_CODE;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel for the current tick; slot 0 reads straight from the buffer
  always_comb begin
    srcOn = (slot == 4'd0) ? bufFull : shValid;
    srcCode = (slot == 4'd0) ? bufCode : shCode;
    srcGlyph = (slot == 4'd0) ? bufGlyph : shGlyph;
    srcAttr = (slot == 4'd0) ? bufAttr : shAttr;
    if (slot < 4'(QW)) pair = srcCode[7:6];
    else if (slot < 4'(2 * QW)) pair = srcCode[5:4];
    else if (slot < 4'(3 * QW)) pair = srcCode[3:2];
    else pair = srcCode[1:0];
    pixVen = 1'b0;
    pixColor = 4'd0;
    if (srcOn) begin
      unique case (lineMode)
        2'd1: begin
          pixVen = |pair;
          unique case (pair)
            2'd0: pixColor = 4'd0;
            2'd1: pixColor = 4'd8;
            2'd2: pixColor = 4'd2;
            default: pixColor = 4'd5;
          endcase
        end
        2'd2: begin
          pixVen = (slot < 4'd8) && srcCode[3'd7 - slot[2:0]];
          pixColor = srcAttr;
        end
        default: begin
          pixVen = (slot < 4'd8) && srcGlyph[3'd7 - slot[2:0]];
          pixColor = srcAttr;
        end
      endcase
    end
  end

  // Prefetch buffer, shifter, slot counter and registered pixel outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bufFull <= 1'b0;
      bufCode <= '0;
      bufGlyph <= '0;
      bufAttr <= '0;
      shValid <= 1'b0;
      shCode <= '0;
      shGlyph <= '0;
      shAttr <= '0;
      slot <= '0;
      shown <= 8'(COLS);
      ven <= 1'b0;
      color <= 4'd0;
      underrun <= 1'b0;
    end else if (line_start) begin
      bufFull <= 1'b0;
      shValid <= 1'b0;
      slot <= '0;
      shown <= '0;
      ven <= 1'b0;
      color <= 4'd0;
      underrun <= 1'b0;
    end else begin
      if (loadBuf) begin
        bufFull <= 1'b1;
        bufCode <= code;
        bufGlyph <= glyph;
        bufAttr <= attr;
      end
      if (pce) begin
        ven <= de && pixVen;
        color <= de ? pixColor : 4'd0;
      end
      if (adv) begin
        slot <= (slot == 4'(PPC - 1)) ? 4'd0 : slot + 4'd1;
        if (slot == 4'd0) begin
          shValid <= bufFull;
          if (bufFull) begin
            bufFull <= 1'b0;
            shCode <= bufCode;
            shGlyph <= bufGlyph;
            shAttr <= bufAttr;
            shown <= shown + 8'd1;
          end else if (shown != 8'(COLS)) begin
            underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule
